// File: rtl/wb_master_pkg.sv
// rtl/wb_master_pkg.sv - shared types and constants for the Wishbone burst master
package wb_master_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WFETCH = 3'd1,
        RSPACE = 3'd2,
        REQ    = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [31:0] ADDR_STEP     = 32'd4;
    localparam logic [3:0]  SEL_ALL       = 4'hF;
    localparam logic [31:0] USER_MEM_BASE = 32'h3800_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with occupancy count, push+pop allowed when full
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_pop   = pop && (count != '0);
    assign do_push  = push && ((count != FULL_COUNT) || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wb_burst_master.sv
// rtl/wb_burst_master.sv - block-transfer Wishbone initiator, one single-word access at a time
module wb_burst_master
    import wb_master_pkg::*;
#(
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [31:0]      wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [31:0]      rd_data,
    output logic             done,
    output logic             err,
    output logic             wb_valid,
    output logic             wbs_we_i,
    output logic [3:0]       wbs_sel_i,
    output logic [31:0]      wbs_dat_i,
    output logic [31:0]      wbs_adr_i,
    input  logic             wbs_ack_o,
    input  logic [31:0]      wbs_dat_o
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW  = $clog2(TIMEOUT);
    localparam logic [FCW-1:0] FIFO_FULL = FCW'(FIFO_DEPTH);
    localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT - 1);

    state_t           state;
    state_t           next_state;
    logic [LEN_W-1:0] remaining;
    logic [TW-1:0]    tcnt;
    logic [FCW-1:0]   fifo_count;
    logic             fifo_push;
    logic             fifo_pop;
    logic             ack;
    logic             room;
    logic             timeout_hit;

    assign wbs_sel_i = SEL_ALL;
    assign ack       = wbs_ack_o && wb_valid;
    assign rd_valid  = (fifo_count != '0);
    assign fifo_pop  = rd_valid && rd_ready;
    assign room      = (fifo_count < FIFO_FULL) || fifo_pop;

    always_comb begin
        next_state  = state;
        cmd_ready   = 1'b0;
        wr_ready    = 1'b0;
        fifo_push   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_len == '0) next_state = DONE;
                    else if (cmd_we)   next_state = WFETCH;
                    else               next_state = RSPACE;
                end
            end
            WFETCH: begin
                wr_ready = 1'b1;
                if (wr_valid) next_state = REQ;
            end
            RSPACE: begin
                if (room) next_state = REQ;
            end
            REQ: begin
                // An ack on the threshold cycle completes normally.
                if (ack) begin
                    fifo_push = !wbs_we_i;
                    if (remaining == LEN_W'(1)) next_state = DONE;
                    else if (wbs_we_i)          next_state = WFETCH;
                    else                        next_state = RSPACE;
                end else if (tcnt == TO_LAST) begin
                    timeout_hit = 1'b1;
                    next_state  = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            wb_valid  <= 1'b0;
            wbs_we_i  <= 1'b0;
            wbs_adr_i <= '0;
            wbs_dat_i <= '0;
            remaining <= '0;
            tcnt      <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
        end else begin
            state    <= next_state;
            wb_valid <= (next_state == REQ);
            done     <= (next_state == DONE);
            tcnt     <= (state == REQ && !ack && !timeout_hit) ? tcnt + 1'b1 : '0;

            if (state == IDLE && cmd_valid) begin
                wbs_adr_i <= word_align(cmd_addr);
                wbs_we_i  <= cmd_we;
                remaining <= cmd_len;
                err       <= 1'b0;
            end
            if (state == WFETCH && wr_valid) wbs_dat_i <= wr_data;
            if (state == REQ && ack) begin
                wbs_adr_i <= wbs_adr_i + ADDR_STEP;
                remaining <= remaining - 1'b1;
            end
            if (timeout_hit) err <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_rd_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (fifo_push),
        .push_data (wbs_dat_o),
        .pop       (fifo_pop),
        .pop_data  (rd_data),
        .count     (fifo_count)
    );

endmodule
